// File: rtl/round_timer.sv
// round_timer: game-round timekeeper for a whack-a-mole style game.
// Counts a round of ROUND_SECS seconds, emitting a one-cycle tick_sec per
// elapsed second and a one-cycle step per mole step, whose period depends
// on the difficulty level latched when the round starts.
// Optional feature: define ROUND_TIMER_PAUSE_EN to honour the pause input;
// without it the pause port is present but ignored and PAUSED is never entered.
module round_timer #(
    parameter logic [27:0] TICK_MAX   = 28'd49_999_999,
    parameter logic [6:0]  ROUND_SECS = 7'd60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] level,
    output logic       tick_sec,
    output logic       step,
    output logic [6:0] seconds_left,
    output logic [1:0] state,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Everything that advances together on an edge lives in one struct so the
    // register and next-state halves stay in lockstep.
    typedef struct packed {
        state_t      st;
        logic [27:0] sec_cnt;
        logic [27:0] step_cnt;
        logic [6:0]  secs;
        logic [1:0]  lvl;
        logic        tick;
        logic        stp;
    } timer_t;

    timer_t cur, nxt;

    logic        pause_eff;
    logic [27:0] step_reload;
    logic [27:0] step_reload_new;
    logic        sec_zero;
    logic        step_zero;

`ifdef ROUND_TIMER_PAUSE_EN
    assign pause_eff = pause;
`else
    // Port kept for pin compatibility; tying it off keeps PAUSED unreachable.
    assign pause_eff = pause & 1'b0;
`endif

    // Step period follows the level latched at start; a new start uses the
    // level presented on that same edge.
    assign step_reload     = TICK_MAX >> cur.lvl;
    assign step_reload_new = TICK_MAX >> level;
    assign sec_zero        = (cur.sec_cnt == 28'd0);
    assign step_zero       = (cur.step_cnt == 28'd0);

    // Next-state and pulse generation; pulses default low every cycle.
    always_comb begin
        nxt      = cur;
        nxt.tick = 1'b0;
        nxt.stp  = 1'b0;
        case (cur.st)
            IDLE, DONE: begin
                if (start) begin
                    nxt.st       = RUN;
                    nxt.sec_cnt  = TICK_MAX;
                    nxt.step_cnt = step_reload_new;
                    nxt.secs     = ROUND_SECS;
                    nxt.lvl      = level;
                end
            end
            RUN, PAUSED: begin
                if (pause_eff) begin
                    // Frozen: counters and seconds hold, no pulses.
                    nxt.st = PAUSED;
                end else begin
                    nxt.st       = RUN;
                    nxt.sec_cnt  = sec_zero  ? TICK_MAX    : cur.sec_cnt - 28'd1;
                    nxt.step_cnt = step_zero ? step_reload : cur.step_cnt - 28'd1;
                    nxt.stp      = step_zero;
                    if (sec_zero) begin
                        nxt.tick = 1'b1;
                        if (cur.secs <= 7'd1) begin
                            // Final second: round ends, a coincident step is dropped.
                            nxt.secs = 7'd0;
                            nxt.st   = DONE;
                            nxt.stp  = 1'b0;
                        end else begin
                            nxt.secs = cur.secs - 7'd1;
                        end
                    end
                end
            end
            default: nxt.st = IDLE;
        endcase
    end

    // State register with synchronous active-low reset clearing everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur.st       <= IDLE;
            cur.sec_cnt  <= 28'd0;
            cur.step_cnt <= 28'd0;
            cur.secs     <= 7'd0;
            cur.lvl      <= 2'd0;
            cur.tick     <= 1'b0;
            cur.stp      <= 1'b0;
        end else begin
            cur <= nxt;
        end
    end

    assign tick_sec     = cur.tick;
    assign step         = cur.stp;
    assign seconds_left = cur.secs;
    assign state        = cur.st;
    assign done         = (cur.st == DONE);

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer with TICK_MAX=3, ROUND_SECS=2.
// Edge k of a sequence is the k-th rising edge counted from the start edge;
// outputs are sampled 1 time unit after that edge.
module tb_round_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic [1:0] level;
    logic       tick_sec;
    logic       step;
    logic [6:0] seconds_left;
    logic [1:0] state;
    logic       done;

    int tests = 0;
    int fails = 0;

    round_timer #(.TICK_MAX(28'd3), .ROUND_SECS(7'd2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pause        (pause),
        .level        (level),
        .tick_sec     (tick_sec),
        .step         (step),
        .seconds_left (seconds_left),
        .state        (state),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for one edge, then check every output against expectations.
    task automatic cyc(input string tag, input int k, input logic st, input logic ps,
                       input logic rs, input logic [1:0] lv, input logic et,
                       input logic es, input int esec, input int est);
        logic [11:0] obs, exp;
        start = st; pause = ps; reset = rs; level = lv;
        @(posedge clk);
        #1;
        obs = {tick_sec, step, seconds_left, state, done};
        exp = {et, es, 7'(esec), 2'(est), (est == 3)};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge %0d: got tick=%b step=%b secs=%0d state=%0d done=%b, expected tick=%b step=%b secs=%0d state=%0d done=%b",
                   tag, k, tick_sec, step, seconds_left, state, done,
                   exp[11], exp[10], exp[9:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic do_reset(input string tag);
        cyc(tag, -1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        start = 1'b0; pause = 1'b0; reset = 1'b0; level = 2'd0;

        // Reset state, including with start/pause asserted.
        do_reset("reset");
        do_reset("reset_hold");
        cyc("idle", -1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 0, 0);

        // Level 0: ticks at 4 and 8, step at 4 only; pause in DONE ignored.
        for (int k = 0; k <= 9; k++)
            cyc("lvl0", k, k == 0, k == 9, 1'b1, 2'd0, (k == 4) || (k == 8), k == 4,
                (k < 4) ? 2 : ((k < 8) ? 1 : 0), (k < 8) ? 1 : 3);

        // Restart from DONE at edge 10: next tick at 14.
        for (int k = 10; k <= 14; k++)
            cyc("restart", k, k == 10, 1'b0, 1'b1, 2'd0, k == 14, k == 14,
                (k < 14) ? 2 : 1, 1);

        do_reset("reset_b");
        // Level 1: step at 2,4,6; later level changes and starts in RUN ignored.
        for (int k = 0; k <= 9; k++)
            cyc("lvl1", k, (k == 0) || (k == 3) || (k == 5), 1'b0, 1'b1,
                (k == 0) ? 2'd1 : 2'd3, (k == 4) || (k == 8),
                (k == 2) || (k == 4) || (k == 6),
                (k < 4) ? 2 : ((k < 8) ? 1 : 0), (k < 8) ? 1 : 3);

        do_reset("reset_c");
        // Level 3: reload 0, step every edge 1..7, none at the final tick.
        for (int k = 0; k <= 9; k++)
            cyc("lvl3", k, k == 0, 1'b0, 1'b1, 2'd3, (k == 4) || (k == 8),
                (k >= 1) && (k <= 7),
                (k < 4) ? 2 : ((k < 8) ? 1 : 0), (k < 8) ? 1 : 3);

        do_reset("reset_d");
        // Pause high at edges 2..4.
        for (int k = 0; k <= 12; k++) begin
`ifdef ROUND_TIMER_PAUSE_EN
            cyc("pause", k, k == 0, (k >= 2) && (k <= 4), 1'b1, 2'd0,
                (k == 7) || (k == 11), k == 7,
                (k < 7) ? 2 : ((k < 11) ? 1 : 0),
                ((k >= 2) && (k <= 4)) ? 2 : ((k < 11) ? 1 : 3));
`else
            cyc("pause_off", k, k == 0, (k >= 2) && (k <= 4), 1'b1, 2'd0,
                (k == 4) || (k == 8), k == 4,
                (k < 4) ? 2 : ((k < 8) ? 1 : 0), (k < 8) ? 1 : 3);
`endif
        end

        do_reset("reset_e");
        // Reset mid-round at edge 5 wins over start; pause in IDLE has no effect.
        for (int k = 0; k <= 4; k++)
            cyc("midrst", k, k == 0, 1'b0, 1'b1, 2'd0, k == 4, k == 4,
                (k < 4) ? 2 : 1, 1);
        cyc("midrst", 5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0);
        cyc("midrst", 6, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 0, 0);
        cyc("midrst", 7, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 SHALL have parameter TICK_MAX, default 28'd49_999_999: one-second down-counter reload value (period TICK_MAX+1 clocks).
REQ-002 SHALL have parameter ROUND_SECS, default 7'd60: round length in seconds, legal range 1..127.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  begin or restart a round, sampled per edge.
REQ-006 SHALL have port pause  input  1  level, freezes round while high.
REQ-007 SHALL have port level  input  2  difficulty, selects step period, latched at start.
REQ-008 SHALL have port tick_sec  output  1  registered one-cycle pulse per elapsed second.
REQ-009 SHALL have port step  output  1  registered one-cycle pulse per mole step.
REQ-010 SHALL have port seconds_left  output  7  remaining round seconds.
REQ-011 SHALL have port state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.
REQ-012 SHALL have port done  output  1  high while state is DONE.

Function
REQ-013 SHALL hold two internal 28-bit down-counters: sec_cnt (reload TICK_MAX) and step_cnt (reload TICK_MAX >> latched level, logical shift).
REQ-014 In IDLE or DONE, start=1 SHALL load sec_cnt=TICK_MAX, step_cnt=reload, seconds_left=ROUND_SECS, latch level, enter RUN at the same edge.
REQ-015 In RUN, each edge SHALL decrement both counters; a counter at 0 SHALL reload instead and pulse its output (tick_sec or step) at that edge.
REQ-016 First tick_sec SHALL appear TICK_MAX+1 edges after the start edge, then every TICK_MAX+1 edges; step likewise with its reload value.
REQ-017 Each tick_sec SHALL decrement seconds_left; the tick taking it 1->0 SHALL pulse tick_sec, set done, enter DONE, and suppress any coincident step.
REQ-018 Reload value 0 (TICK_MAX or shifted result) SHALL yield a pulse every edge in RUN.
REQ-019 start while in RUN or PAUSED SHALL be ignored.
REQ-020 In RUN, pause=1 SHALL enter PAUSED at that edge with no decrement and no pulse at that edge.
REQ-021 In PAUSED, counters and seconds_left SHALL hold, tick_sec and step SHALL be 0; pause=0 SHALL return to RUN, counting resuming at the next edge.
REQ-022 DONE SHALL hold seconds_left=0 and done=1 until start or reset; pause SHALL have no effect outside RUN/PAUSED.
REQ-023 tick_sec and step SHALL be 0 in every cycle not named above.

Reset
REQ-024 reset=0 at a clock edge SHALL force state=IDLE, seconds_left=0, tick_sec=0, step=0, done=0, both counters=0, latched level=0, overriding all other inputs including mid-round.
REQ-025 No output SHALL change asynchronously to clk.

Configuration
REQ-026 Macro ROUND_TIMER_PAUSE_EN defined: pause behaves per REQ-020..021.
REQ-027 Macro ROUND_TIMER_PAUSE_EN undefined: pause port SHALL remain but be ignored; PAUSED state SHALL be unreachable.

Verification (TICK_MAX=3, ROUND_SECS=2, start pulsed at edge 0)
REQ-028 level=0 -> tick_sec at edges 4 and 8; seconds_left 2,1,0; step at edge 4 only; done=1 and state=3 from edge 8.
REQ-029 level=1 (reload 1) -> step at edges 2,4,6; none at 8; done at 8.
REQ-030 level=3 (reload 0) -> step every edge 1..7; tick_sec at 4 and 8.
REQ-031 pause=1 at edges 2..4, macro defined -> state=2 edges 2..4, no pulses, first tick_sec at edge 7; macro undefined -> unchanged from REQ-028.
REQ-032 reset=0 at edge 5 mid-round -> edge 5 shows state=0, seconds_left=0, all pulses 0; start at edge 0 again during RUN ignored.
REQ-033 start at edge 10 in DONE -> done=0, seconds_left=2, state=1; next tick_sec at edge 14.
